fifo_tx_drain_ctrl: RTL and testbench



---
 rtl/uart_sys_pkg.sv | 24 ++
 rtl/gap_timer.sv | 36 +++
 rtl/fifo_tx_drain_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_tx_drain_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sys_pkg.sv
// Shared UART-subsystem definitions: the drain controller's state encoding and
// the width of its transmitted-byte counter.
package uart_sys_pkg;

   localparam logic [1:0] DRN_IDLE      = 2'd0;
   localparam logic [1:0] DRN_SEND      = 2'd1;
   localparam logic [1:0] DRN_WAIT_DONE = 2'd2;
   localparam logic [1:0] DRN_GAP       = 2'd3;

   localparam int BYTE_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = DRN_IDLE,
      ST_SEND      = DRN_SEND,
      ST_WAIT_DONE = DRN_WAIT_DONE,
      ST_GAP       = DRN_GAP
   } drn_state_e;

   // Free-running wrap 255 -> 0 is intended.
   function automatic logic [BYTE_CNT_W-1:0] cnt_inc(input logic [BYTE_CNT_W-1:0] c);
      return c + BYTE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/gap_timer.sv
// Load/decrement down-counter that times the idle gap between frames;
// done_o is high whenever the count has reached zero.
module gap_timer #(
   parameter int GAP_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [GAP_WIDTH-1:0] load_val_i,
   input  logic                 dec_i,
   output logic                 done_o
);

   logic [GAP_WIDTH-1:0] count_q;
   logic [GAP_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - GAP_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/fifo_tx_drain_ctrl.sv
// Drains the async byte FIFO into the UART transmitter, one pop per frame,
// with a programmable idle gap after each frame and a transmitted-byte count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for tx_en, data in FIFO and UART not busy
// SEND      | byte popped and presented; holding request until busy seen
// WAIT_DONE | UART accepted the byte; waiting for busy to fall
// GAP       | enforced idle clocks before the next pop may be considered
module fifo_tx_drain_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 0,
   parameter int GAP_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_r_inc,
   input  logic                  tx_busy,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_data_valid,
   output logic                  drain_active,
   output logic [7:0]            byte_count
);

   import uart_sys_pkg::*;

   // The counter is loaded on the completing edge, so GAP_CYCLES-1 yields
   // exactly GAP_CYCLES clocks spent in GAP.
   localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
      GAP_WIDTH'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   drn_state_e              state_q;
   logic [DATA_WIDTH-1:0]   tx_data_q;
   logic                    tx_data_valid_q;
   logic                    fifo_r_inc_q;
   logic                    drain_active_q;
   logic [BYTE_CNT_W-1:0]   byte_count_q;

   logic start_frame;
   logic gap_load;
   logic gap_dec;
   logic gap_done;

   assign start_frame = tx_en && !fifo_empty && !tx_busy;
   assign gap_load    = (state_q == ST_WAIT_DONE) && !tx_busy && (GAP_CYCLES != 0);
   assign gap_dec     = (state_q == ST_GAP);

   gap_timer #(
      .GAP_WIDTH (GAP_WIDTH)
   ) u_gap_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (gap_load),
      .load_val_i (GAP_LOAD),
      .dec_i      (gap_dec),
      .done_o     (gap_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         tx_data_q       <= '0;
         tx_data_valid_q <= 1'b0;
         fifo_r_inc_q    <= 1'b0;
         drain_active_q  <= 1'b0;
         byte_count_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_frame) begin
                  tx_data_q       <= fifo_rd_data;
                  tx_data_valid_q <= 1'b1;
                  fifo_r_inc_q    <= 1'b1;
                  drain_active_q  <= 1'b1;
                  state_q         <= ST_SEND;
               end
            end
            ST_SEND: begin
               fifo_r_inc_q <= 1'b0;
               if (tx_busy) begin
                  tx_data_valid_q <= 1'b0;
                  state_q         <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  byte_count_q <= cnt_inc(byte_count_q);
                  if (GAP_CYCLES == 0) begin
                     drain_active_q <= 1'b0;
                     state_q        <= ST_IDLE;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  drain_active_q <= 1'b0;
                  state_q        <= ST_IDLE;
               end
            end
            default: begin
               drain_active_q <= 1'b0;
               state_q        <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_data_valid_q;
   assign fifo_r_inc    = fifo_r_inc_q;
   assign drain_active  = drain_active_q;
   assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Bench for fifo_tx_drain_ctrl: FIFO and UART TX modelled as queues/counters,
// outputs checked every cycle against a frame-lifecycle reference model.
module tb_fifo_tx_drain_ctrl;

   localparam int DW  = 8;
   localparam int GAP = 3;
   localparam int GW  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tx_en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          u_busy = 1'b0;
   logic          hold_busy = 1'b0;
   logic          tx_busy;
   logic          fifo_r_inc;
   logic [DW-1:0] tx_data;
   logic          tx_data_valid;
   logic          drain_active;
   logic [7:0]    byte_count;

   assign tx_busy = u_busy | hold_busy;

   always #5 clk = ~clk;

   fifo_tx_drain_ctrl #(
      .DATA_WIDTH (DW),
      .GAP_CYCLES (GAP),
      .GAP_WIDTH  (GW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_en         (tx_en),
      .fifo_empty    (fifo_empty),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_r_inc    (fifo_r_inc),
      .tx_busy       (tx_busy),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .drain_active  (drain_active),
      .byte_count    (byte_count)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] fq[$];
   logic [7:0] order_q[$];

   // UART model
   int         busy_len = 10;
   int         acc_dly = 0;
   int         u_busy_cnt = 0;
   int         u_dly_cnt = 0;
   bit         rnd_mode = 0;
   int         acc_n = 0;
   logic [7:0] last_acc = '0;

   // observation counters
   int pops = 0;
   int gap_samp = 0;
   int valid_samp = 0;

   // reference model: a frame is in flight from pop to completion, accepted once busy seen
   bit         m_fl = 0;
   bit         m_acc = 0;
   int         m_gap = 0;
   logic [7:0] m_data = '0;
   int         m_cnt = 0;
   bit         m_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty   = (fq.size() == 0);
      fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      order_q.push_back(b);
      drive_fifo();
   endtask

   task automatic model_step();
      m_pop = 0;
      if (!rst) begin
         m_fl = 0; m_acc = 0; m_gap = 0; m_data = '0; m_cnt = 0;
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (!m_fl) begin
         if (tx_en && (fq.size() > 0) && !tx_busy) begin
            m_fl = 1; m_acc = 0; m_data = fq[0]; m_pop = 1;
         end
      end else if (!m_acc) begin
         if (tx_busy) m_acc = 1;
      end else if (!tx_busy) begin
         m_cnt++;
         m_fl = 0;
         m_gap = GAP;
      end
   endtask

   task automatic uart_accept();
      u_busy     = 1'b1;
      u_busy_cnt = busy_len;
      acc_n++;
      last_acc   = tx_data;
      if (order_q.size() > 0) begin
         chk("tx_order", tx_data, order_q.pop_front());
      end else begin
         vectors++;
         miscompares++;
         $display("FAIL tx_order: got unexpected frame %0h expected none at %0t", tx_data, $time);
      end
      if (rnd_mode) begin
         busy_len = $urandom_range(1, 4);
         acc_dly  = $urandom_range(0, 2);
      end
   endtask

   task automatic uart_step();
      if (u_busy_cnt > 0) begin
         u_busy_cnt--;
         if (u_busy_cnt == 0) u_busy = 1'b0;
      end else if (u_dly_cnt > 0) begin
         u_dly_cnt--;
         if (u_dly_cnt == 0) uart_accept();
      end else if (tx_data_valid && !(u_busy || hold_busy)) begin
         if (acc_dly == 0) uart_accept();
         else u_dly_cnt = acc_dly;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      model_step();
      chk("fifo_r_inc", fifo_r_inc, m_pop);
      chk("tx_data_valid", tx_data_valid, m_fl && !m_acc);
      chk("tx_data", tx_data, m_data);
      chk("drain_active", drain_active, m_fl || (m_gap > 0));
      chk("byte_count", byte_count, m_cnt % 256);
      if (drain_active && !tx_data_valid && !tx_busy) gap_samp++;
      if (tx_data_valid) valid_samp++;
      if (fifo_r_inc) begin
         pops++;
         if (fq.size() > 0) void'(fq.pop_front());
      end
      uart_step();
      drive_fifo();
   endtask

   task automatic run_until_idle(input int n_acc, input int max);
      int c = 0;
      while (!(acc_n >= n_acc && !drain_active && !(u_busy || hold_busy)) && c < max) begin
         cyc();
         c++;
      end
      if (c >= max) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got %0d frames expected %0d within %0d cycles", acc_n, n_acc, max);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, a0, c;
      drive_fifo();
      #2;
      chk("rst_r_inc", fifo_r_inc, 0);
      chk("rst_valid", tx_data_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_active", drain_active, 0);
      chk("rst_count", byte_count, 0);
      cyc(); cyc();
      rst = 1'b1;
      cyc();

      // single byte
      busy_len = 10; acc_dly = 0; gap_samp = 0;
      push(8'hA5);
      tx_en = 1'b1;
      run_until_idle(1, 200);
      chk("single_pops", pops, 1);
      chk("single_data", last_acc, 8'hA5);
      chk("single_count", byte_count, 1);
      chk("single_gap", gap_samp, GAP);
      repeat (10) cyc();
      chk("single_no_repop", pops, 1);

      // burst of three with gap
      busy_len = 4; gap_samp = 0; a0 = acc_n;
      push(8'h01); push(8'h02); push(8'h03);
      run_until_idle(a0 + 3, 400);
      chk("burst_frames", acc_n - a0, 3);
      chk("burst_last", last_acc, 8'h03);
      chk("burst_count", byte_count, 4);
      chk("burst_gap", gap_samp, 3 * GAP);

      // slow accept
      acc_dly = 5; busy_len = 3; valid_samp = 0; p0 = pops; a0 = acc_n;
      push(8'h5A);
      run_until_idle(a0 + 1, 200);
      chk("slow_valid_hold", valid_samp, 6);
      chk("slow_pops", pops - p0, 1);
      chk("slow_data", last_acc, 8'h5A);
      acc_dly = 0;

      // enable gating
      tx_en = 1'b0; p0 = pops; a0 = acc_n; busy_len = 4;
      push(8'h11); push(8'h22);
      repeat (15) cyc();
      chk("gate_no_pop", pops - p0, 0);
      tx_en = 1'b1;
      cyc();
      tx_en = 1'b0;
      run_until_idle(a0 + 1, 200);
      repeat (8) cyc();
      chk("gate_frames", acc_n - a0, 1);
      chk("gate_fifo_left", fq.size(), 1);

      // reset during WAIT_DONE
      busy_len = 10; a0 = acc_n;
      push(8'h3C);
      tx_en = 1'b1;
      c = 0;
      while (!(drain_active && !tx_data_valid && u_busy && acc_n > a0) && c < 100) begin
         cyc();
         c++;
      end
      chk("rstmid_reached", (c < 100), 1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_r_inc", fifo_r_inc, 0);
      chk("rstmid_valid", tx_data_valid, 0);
      chk("rstmid_data", tx_data, 0);
      chk("rstmid_active", drain_active, 0);
      chk("rstmid_count", byte_count, 0);
      cyc(); cyc();
      rst = 1'b1;
      run_until_idle(a0 + 2, 300);
      chk("rstmid_next", last_acc, 8'h3C);
      chk("rstmid_count_after", byte_count, 1);

      // 256 randomized frames wrap the counter
      rst = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      rnd_mode = 1; a0 = acc_n;
      for (int i = 0; i < 256; i++) push(8'($urandom));
      c = 0;
      while (!(acc_n >= a0 + 256 && !drain_active && !(u_busy || hold_busy)) && c < 30000) begin
         tx_en = ($urandom_range(0, 9) != 0);
         cyc();
         c++;
      end
      chk("wrap_in_time", (c < 30000), 1);
      chk("wrap_frames", acc_n - a0, 256);
      chk("wrap_count", byte_count, 0);
      rnd_mode = 0; busy_len = 3; acc_dly = 0;

      // busy held in IDLE blocks the pop
      tx_en = 1'b0;
      repeat (4) cyc();
      hold_busy = 1'b1; p0 = pops; a0 = acc_n;
      push(8'h77);
      tx_en = 1'b1;
      repeat (12) cyc();
      chk("busy_block_pops", pops - p0, 0);
      hold_busy = 1'b0;
      run_until_idle(a0 + 1, 200);
      chk("busy_block_data", last_acc, 8'h77);
      chk("busy_block_count", byte_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
